// File: rtl/pll_reconfig_seq.sv
// Fractional-PLL reconfiguration sequencer: filters the PAL/NTSC request, writes
// mode/K/start to the PLL reconfig slave, waits for re-lock and holds the core meanwhile.
module pll_reconfig_seq #(
  parameter logic [31:0] K_PAL      = 32'h15448515,
  parameter logic [31:0] K_NTSC     = 32'h29E2B79B,
  parameter int unsigned STABLE_CYC = 1024,
  parameter int unsigned UNLOCK_TO  = 256,
  parameter int unsigned LOCK_TO    = 5000000,
  parameter int unsigned SETTLE_CYC = 64
) (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic        mode_req,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        applied_mode
);

  localparam int unsigned T_MAX = (LOCK_TO > UNLOCK_TO)
                                ? ((LOCK_TO > SETTLE_CYC) ? LOCK_TO : SETTLE_CYC)
                                : ((UNLOCK_TO > SETTLE_CYC) ? UNLOCK_TO : SETTLE_CYC);
  localparam int unsigned TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  localparam logic [SW-1:0] STAB_LAST   = SW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_TO - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TO - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_K     = 6'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MODE, S_WR_K, S_WR_START, S_WAIT_UNLOCK, S_WAIT_LOCK, S_SETTLE
  } state_t;

  state_t        r_state, w_state;
  logic          r_mode_s1, r_mode_s2, r_mode_q, r_lock_s1, r_lock_s2;
  logic [SW-1:0] r_stab_cnt;
  logic [TW-1:0] r_timer, w_timer;
  logic          r_write, w_write;
  logic [5:0]    r_addr, w_addr;
  logic [31:0]   r_data, w_data;
  logic          r_hold, w_hold, r_busy, w_busy, r_done, w_done, r_error, w_error;
  logic          r_applied, w_applied, r_force, w_force, r_tgt, w_tgt;
  logic          w_stable, w_accept;
  logic [5:0]    w_wr_addr;
  logic [31:0]   w_wr_data;
  state_t        w_wr_next;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_mode_s1  <= 1'b0;
      r_mode_s2  <= 1'b0;
      r_mode_q   <= 1'b0;
      r_lock_s1  <= 1'b0;
      r_lock_s2  <= 1'b0;
      r_stab_cnt <= '0;
    end else begin
      r_mode_s1 <= mode_req;
      r_mode_s2 <= r_mode_s1;
      r_mode_q  <= r_mode_s2;
      r_lock_s1 <= pll_locked;
      r_lock_s2 <= r_lock_s1;
      if (r_mode_s2 != r_mode_q)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != STAB_LAST)
        r_stab_cnt <= r_stab_cnt + SW'(1);
    end
  end

  // Counter saturates, so a mismatch still pending when the FSM returns to IDLE is accepted at once.
  assign w_stable = (r_stab_cnt == STAB_LAST) && (r_mode_s2 == r_mode_q);
  assign w_accept = w_stable && ((r_mode_q != r_applied) || r_force);

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_hold    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_applied <= 1'b0;
      r_force   <= 1'b1;
      r_tgt     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_write   <= w_write;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_hold    <= w_hold;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_error   <= w_error;
      r_applied <= w_applied;
      r_force   <= w_force;
      r_tgt     <= w_tgt;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer;
    w_write   = r_write;
    w_addr    = r_addr;
    w_data    = r_data;
    w_hold    = r_hold;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_error   = r_error;
    w_applied = r_applied;
    w_force   = r_force;
    w_tgt     = r_tgt;
    w_wr_addr = ADDR_MODE;
    w_wr_data = '0;
    w_wr_next = S_WR_K;

    case (r_state)
      S_WR_K: begin
        w_wr_addr = ADDR_K;
        w_wr_data = r_tgt ? K_NTSC : K_PAL;
        w_wr_next = S_WR_START;
      end
      S_WR_START: begin
        w_wr_addr = ADDR_START;
        w_wr_next = S_WAIT_UNLOCK;
      end
      default: ;
    endcase

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_tgt   = r_mode_q;
          w_busy  = 1'b1;
          w_hold  = 1'b1;
          w_write = 1'b1;
          w_addr  = ADDR_MODE;
          w_data  = '0;
          w_state = S_WR_MODE;
        end
      end
      // A write is launched in the gap cycle and retired on the first non-stalled cycle.
      S_WR_MODE, S_WR_K, S_WR_START: begin
        if (!r_write) begin
          w_write = 1'b1;
          w_addr  = w_wr_addr;
          w_data  = w_wr_data;
        end else if (!mgmt_waitrequest) begin
          w_write = 1'b0;
          w_state = w_wr_next;
          w_timer = '0;
        end
      end
      S_WAIT_UNLOCK: begin
        if (!r_lock_s2 || (r_timer == UNLOCK_LAST)) begin
          w_state = S_WAIT_LOCK;
          w_timer = '0;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (r_lock_s2) begin
          w_state = S_SETTLE;
          w_timer = '0;
        end else if (r_timer == LOCK_LAST) begin
          w_error = 1'b1;
          w_busy  = 1'b0;
          w_hold  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_SETTLE: begin
        if (r_timer == SETTLE_LAST) begin
          w_applied = r_tgt;
          w_force   = 1'b0;
          w_error   = 1'b0;
          w_done    = 1'b1;
          w_busy    = 1'b0;
          w_hold    = 1'b0;
          w_state   = S_IDLE;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign mgmt_write     = r_write & ~reset;
  assign mgmt_address   = r_addr;
  assign mgmt_writedata = r_data;
  assign core_hold      = r_hold;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign applied_mode   = r_applied;

endmodule
